// File: rtl/count_capture.sv
// Counter-sample capture FIFO: records {wrap, count} into a first-word fall-through queue.
// Optional macro COUNT_CAPTURE_DROP_CNT_EN enables the saturating dropped-capture counter.
module count_capture #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         cnt_in,
    input  logic                     cap_en,
    output logic [WIDTH:0]           out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf_sticky,
    input  logic                     clr_ovf,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_nxt;
    logic [WIDTH-1:0] prev_cnt;
    logic             valid_q;
    logic             full_q;
    logic             empty_q;
    logic             ovf_q;
    logic             wrap;
    logic             push;
    logic             pop;
    logic             drop;

    always_comb begin
        wrap      = (cnt_in < prev_cnt);
        pop       = valid_q && out_ready;
        // A full FIFO still accepts a capture when the head leaves in the same cycle
        push      = cap_en && (!full_q || pop);
        drop      = cap_en && full_q && !pop;
        level_nxt = level_q;
        if (push && !pop)
            level_nxt = level_q + LW'(1);
        else if (pop && !push)
            level_nxt = level_q - LW'(1);
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {wrap, cnt_in};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            prev_cnt <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            prev_cnt <= cnt_in;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level_q <= level_nxt;
            valid_q <= (level_nxt != '0);
            empty_q <= (level_nxt == '0);
            full_q  <= (level_nxt == LW'(DEPTH));
            if (drop)
                ovf_q <= 1'b1;
            else if (clr_ovf)
                ovf_q <= 1'b0;
        end
    end

`ifdef COUNT_CAPTURE_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
        end else if (clr_ovf) begin
            drop_q <= drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

    assign out_data   = mem[rd_ptr];
    assign out_valid  = valid_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign level      = level_q;
    assign ovf_sticky = ovf_q;

endmodule
